vc_sdf_bf2: RTL and testbench
=============================

# vc_sdf_bf2

Radix-2 single-path delay-feedback (SDF) butterfly stage for the pipelined FFT datapath. It accepts one complex sample per non-stalled cycle and pairs samples DELAY apart through an internal feedback delay line. It emits the butterfly sum followed by the difference, with one bit of growth, into the downstream stall-aware register/twiddle stage. A chain of these stages (DELAY = N/2, N/4, …, 1) forms the FFT core.

## Interface
- DWIDTH, 24: input sample width per real/imag part, two's complement.
- DELAY, 8: feedback delay depth in samples; power of two, ≥ 1.
- clk  in  1  rising-edge clock.
- n_rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- stall  in  1  when high, the stage holds all state: counter, delay line, outputs and flags.
- D_re, D_im  in  DWIDTH each  signed input sample, consumed on every clk edge with stall=0.
- Q_re, Q_im  out  DWIDTH+1 each  registered signed butterfly result.
- Q_diff  out  1  0 = Q is a sum (upper branch), 1 = Q is a difference (lower branch, needs twiddle).
- Q_k  out  log2(DELAY) (min 1)  index of Q within its half-block; the downstream twiddle address.
- Q_valid  out  1  high once the first real butterfly output is on Q.

## Operation
- Reset (n_rst=0 at an edge, stall ignored): cnt=0; all delay-line entries=0; Q_re=Q_im=0; Q_diff=0; Q_k=0; Q_valid=0.
- cnt: log2(2·DELAY)-bit counter. It increments by 1 on each accepted cycle (stall=0) and wraps from 2·DELAY-1 to 0. phase = cnt MSB. k = cnt low log2(DELAY) bits; for DELAY=1, k is always 0.
- Delay line: a DELAY-entry FIFO of complex words, DWIDTH+1 bits per part. It shifts exactly once per accepted cycle. head = oldest entry.
- Phase 0, fill/drain: push sign-extended D. The result is head, the stored difference from the previous block.
- Phase 1, butterfly: result = head + sext(D); push head − sext(D). All arithmetic is DWIDTH+1 bits wide, with no saturation and no rounding. The fill value had DWIDTH significant bits, so overflow is impossible.
- On every accepted cycle the output register loads the result: Q_diff ← ~phase, Q_k ← k. In phase 1 the emitted sample is a sum, so Q_diff=0. In phase 0 it is a difference, so Q_diff=1.
- Q_valid goes to 1 on the first accepted cycle with phase=1 after reset and stays 1 until the next reset. Phase-0 outputs before that point are zeros from the reset delay line.
- Stall: no state changes at all; D is ignored; Q holds.
- Stall and reset in the same cycle: reset wins.

## Timing
- Number the accepted cycles after reset 0, 1, 2, … with input sample x[i] consumed at accepted cycle i.
- Sum x[j]+x[j+DELAY] (j = 0..DELAY-1 within each 2·DELAY block) appears on Q after the edge of accepted cycle j+DELAY. That is one accepted cycle of latency from the second operand.
- Difference x[j]−x[j+DELAY] appears after the edge of accepted cycle j+2·DELAY. This overlaps the next block's fill.
- Steady-state throughput is 1 sample per accepted cycle, with no bubbles across block boundaries.
- Stall cycles extend all latencies 1:1; the output sequence is identical to the unstalled sequence.
- Reset mid-block discards all partial state. The next accepted sample is x[0] of a new block.

## Test plan
- Basic, DELAY=4, DWIDTH=24, imag=0, D_re=1..8 with no stall:
  - Q_valid rises on Q after accepted cycle 4.
  - Q_re = 6, 8, 10, 12 with Q_diff=0 and Q_k=0..3.
  - Then Q_re = −4 ×4 with Q_diff=1 and Q_k=0..3.
  - Continuing with D_re=0 yields sums equal to the new samples.
- Complex path: D=(3,−2) then D=(1,5) at distance DELAY → sum (4,3) then difference (2,−7).
- Width extremes: D_re=2^23−1 paired with 2^23−1 → sum 2^24−2. D_re=−2^23 paired with 2^23−1 → diff −2^24+1. Both exact in 25 bits.
- Random stall, ~30% duty, over 3 blocks of random data: the Q/Q_diff/Q_k sequence sampled on accepted cycles matches a zero-stall golden model, and Q stays unchanged on every stall cycle.
- Reset mid-block after 5 samples (DELAY=4):
  - All outputs are 0 and Q_valid=0 on the next cycle.
  - A fresh 1..8 sequence reproduces the basic scenario exactly, with no leftovers from the old delay line.
- DELAY=1: D=10, 4, 7, 1 → Q = 14 (Q_diff=0), 6 (Q_diff=1), 8 (Q_diff=0), 6 (Q_diff=1), with Q_k=0 throughout.

Source files
------------

// File: rtl/vc_sdf_bf2.sv
// Radix-2 single-path delay-feedback butterfly stage: pairs samples DELAY apart,
// emits the sum during the second half-block and the stored difference during the next fill.
module vc_sdf_bf2 #(
  parameter int unsigned DWIDTH = 24,
  parameter int unsigned DELAY  = 8,
  localparam int unsigned KW    = (DELAY > 1) ? $clog2(DELAY) : 1
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     stall,
  input  logic signed [DWIDTH-1:0] D_re,
  input  logic signed [DWIDTH-1:0] D_im,
  output logic signed [DWIDTH:0]   Q_re,
  output logic signed [DWIDTH:0]   Q_im,
  output logic                     Q_diff,
  output logic [KW-1:0]            Q_k,
  output logic                     Q_valid
);

  localparam int unsigned CW = $clog2(2 * DELAY);
  localparam int unsigned OW = DWIDTH + 1;

  logic [CW-1:0]        cnt;
  logic signed [OW-1:0] dl_re [DELAY];
  logic signed [OW-1:0] dl_im [DELAY];

  logic                 phase_c;
  logic [KW-1:0]        k_c;
  logic signed [OW-1:0] sext_re_c, sext_im_c;
  logic signed [OW-1:0] head_re_c, head_im_c;
  logic signed [OW-1:0] res_re_c, res_im_c;
  logic signed [OW-1:0] push_re_c, push_im_c;

  // Phase 1 folds the incoming sample into the waiting one; phase 0 refills and drains.
  always_comb begin
    phase_c   = cnt[CW-1];
    k_c       = (DELAY > 1) ? cnt[KW-1:0] : '0;
    sext_re_c = {D_re[DWIDTH-1], D_re};
    sext_im_c = {D_im[DWIDTH-1], D_im};
    head_re_c = dl_re[DELAY-1];
    head_im_c = dl_im[DELAY-1];
    res_re_c  = head_re_c;
    res_im_c  = head_im_c;
    push_re_c = sext_re_c;
    push_im_c = sext_im_c;
    if (phase_c) begin
      res_re_c  = head_re_c + sext_re_c;
      res_im_c  = head_im_c + sext_im_c;
      push_re_c = head_re_c - sext_re_c;
      push_im_c = head_im_c - sext_im_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt     <= '0;
      Q_re    <= '0;
      Q_im    <= '0;
      Q_diff  <= 1'b0;
      Q_k     <= '0;
      Q_valid <= 1'b0;
      for (int i = 0; i < int'(DELAY); i++) begin
        dl_re[i] <= '0;
        dl_im[i] <= '0;
      end
    end else if (!stall) begin
      cnt      <= cnt + CW'(1);
      dl_re[0] <= push_re_c;
      dl_im[0] <= push_im_c;
      for (int i = 1; i < int'(DELAY); i++) begin
        dl_re[i] <= dl_re[i-1];
        dl_im[i] <= dl_im[i-1];
      end
      Q_re   <= res_re_c;
      Q_im   <= res_im_c;
      Q_diff <= ~phase_c;
      Q_k    <= k_c;
      if (phase_c) Q_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_sdf_bf2.sv
// Randomized bench for vc_sdf_bf2 (DELAY=4 and DELAY=1) against a block-level butterfly model.
module tb_vc_sdf_bf2;

  localparam int unsigned DW  = 24;
  localparam int          D4  = 4;
  localparam int          MAXV = (1 << 23) - 1;
  localparam int          MINV = -(1 << 23);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 n_rst4, stall4;
  logic signed [DW-1:0] d4_re, d4_im;
  logic signed [DW:0]   q4_re, q4_im;
  logic                 q4_diff, q4_valid;
  logic [1:0]           q4_k;

  logic                 n_rst1, stall1;
  logic signed [DW-1:0] d1_re, d1_im;
  logic signed [DW:0]   q1_re, q1_im;
  logic                 q1_diff, q1_valid;
  logic [0:0]           q1_k;

  vc_sdf_bf2 #(.DWIDTH(DW), .DELAY(4)) u_dut4 (
    .clk(clk), .n_rst(n_rst4), .stall(stall4), .D_re(d4_re), .D_im(d4_im),
    .Q_re(q4_re), .Q_im(q4_im), .Q_diff(q4_diff), .Q_k(q4_k), .Q_valid(q4_valid));

  vc_sdf_bf2 #(.DWIDTH(DW), .DELAY(1)) u_dut1 (
    .clk(clk), .n_rst(n_rst1), .stall(stall1), .D_re(d1_re), .D_im(d1_im),
    .Q_re(q1_re), .Q_im(q1_im), .Q_diff(q1_diff), .Q_k(q1_k), .Q_valid(q1_valid));

  int n_cmp = 0;
  int n_bad = 0;
  int xr[$];
  int xi[$];

  // Expected Q after the edge of accepted cycle i, straight from the block pairing rule.
  function automatic void model4(input int i, output int er, output int ei,
                                 output logic ed, output int ek, output logic ev);
    int b, p;
    er = 0; ei = 0; ed = 1'b0; ek = 0; ev = 1'b0;
    if (i < 0) return;
    b  = i / (2 * D4);
    p  = i % (2 * D4);
    ev = (i >= D4);
    if (p >= D4) begin
      er = xr[i-D4] + xr[i];
      ei = xi[i-D4] + xi[i];
      ed = 1'b0;
      ek = p - D4;
    end else begin
      ed = 1'b1;
      ek = p;
      if (b > 0) begin
        er = xr[i-2*D4] - xr[i-D4];
        ei = xi[i-2*D4] - xi[i-D4];
      end
    end
  endfunction

  task automatic cyc4(input logic st, input int re, input int im);
    stall4 = st;
    d4_re  = DW'(re);
    d4_im  = DW'(im);
    @(posedge clk);
    #1;
    if (!st) begin
      xr.push_back(re);
      xi.push_back(im);
    end
  endtask

  task automatic rst4(input logic st);
    n_rst4 = 1'b0;
    stall4 = st;
    d4_re  = DW'($urandom);
    d4_im  = DW'($urandom);
    @(posedge clk);
    #1;
    n_rst4 = 1'b1;
    stall4 = 1'b0;
    xr.delete();
    xi.delete();
  endtask

  function automatic int rnd24();
    logic signed [DW-1:0] r;
    r = DW'($urandom);
    return int'(r);
  endfunction

  task automatic test_reset();
    int er, ei, ek;
    logic ed, ev;
    rst4(1'b1);
    model4(xr.size() - 1, er, ei, ed, ek, ev);
    n_cmp++;
    if (q4_re !== 25'(er) || q4_im !== 25'(ei) || q4_diff !== ed || q4_k !== 2'(ek) || q4_valid !== ev) begin
      n_bad++;
      $display("FAIL reset: got re=%0d im=%0d diff=%b k=%0d valid=%b, want re=%0d im=%0d diff=%b k=%0d valid=%b",
               q4_re, q4_im, q4_diff, q4_k, q4_valid, er, ei, ed, ek, ev);
    end
  endtask

  task automatic test_basic();
    int er, ei, ek;
    logic ed, ev;
    rst4(1'b0);
    for (int n = 0; n < 16; n++) begin
      cyc4(1'b0, (n < 8) ? n + 1 : 0, 0);
      model4(xr.size() - 1, er, ei, ed, ek, ev);
      n_cmp++;
      if (q4_re !== 25'(er) || q4_im !== 25'(ei) || q4_diff !== ed || q4_k !== 2'(ek) || q4_valid !== ev) begin
        n_bad++;
        $display("FAIL basic[%0d]: got re=%0d im=%0d diff=%b k=%0d valid=%b, want re=%0d im=%0d diff=%b k=%0d valid=%b",
                 n, q4_re, q4_im, q4_diff, q4_k, q4_valid, er, ei, ed, ek, ev);
      end
    end
    // Spot value: first sum 1+5 after accepted cycle 4 of the fresh block.
    if (xr.size() > 4) begin
      n_cmp++;
      if (xr[0] + xr[4] != 6) begin
        n_bad++;
        $display("FAIL basic_seq: got %0d, want 6", xr[0] + xr[4]);
      end
    end
  endtask

  task automatic test_complex();
    int er, ei, ek;
    logic ed, ev;
    int sr[12];
    int si[12];
    rst4(1'b0);
    for (int n = 0; n < 12; n++) begin
      sr[n] = rnd24();
      si[n] = rnd24();
    end
    sr[0] = 3; si[0] = -2;
    sr[4] = 1; si[4] = 5;
    for (int n = 8; n < 12; n++) begin
      sr[n] = 0;
      si[n] = 0;
    end
    for (int n = 0; n < 12; n++) begin
      cyc4(1'b0, sr[n], si[n]);
      model4(xr.size() - 1, er, ei, ed, ek, ev);
      n_cmp++;
      if (q4_re !== 25'(er) || q4_im !== 25'(ei) || q4_diff !== ed || q4_k !== 2'(ek) || q4_valid !== ev) begin
        n_bad++;
        $display("FAIL complex[%0d]: got re=%0d im=%0d diff=%b k=%0d valid=%b, want re=%0d im=%0d diff=%b k=%0d valid=%b",
                 n, q4_re, q4_im, q4_diff, q4_k, q4_valid, er, ei, ed, ek, ev);
      end
      if (n == 4 || n == 8) begin
        n_cmp++;
        if (q4_re !== ((n == 4) ? 25'sd4 : 25'sd2) || q4_im !== ((n == 4) ? 25'sd3 : -25'sd7)) begin
          n_bad++;
          $display("FAIL complex_pair[%0d]: got (%0d,%0d)", n, q4_re, q4_im);
        end
      end
    end
  endtask

  task automatic test_extremes();
    int er, ei, ek;
    logic ed, ev;
    int sr[12];
    rst4(1'b0);
    sr = '{MAXV, MINV, 0, 0, MAXV, MAXV, 0, 0, 0, 0, 0, 0};
    for (int n = 0; n < 12; n++) begin
      cyc4(1'b0, sr[n], (n == 1) ? MINV : MAXV);
      model4(xr.size() - 1, er, ei, ed, ek, ev);
      n_cmp++;
      if (q4_re !== 25'(er) || q4_im !== 25'(ei) || q4_diff !== ed || q4_k !== 2'(ek) || q4_valid !== ev) begin
        n_bad++;
        $display("FAIL extremes[%0d]: got re=%0d im=%0d diff=%b k=%0d valid=%b, want re=%0d im=%0d diff=%b k=%0d valid=%b",
                 n, q4_re, q4_im, q4_diff, q4_k, q4_valid, er, ei, ed, ek, ev);
      end
      if (n == 4 || n == 9) begin
        n_cmp++;
        if (q4_re !== ((n == 4) ? 25'sd16777214 : -25'sd16777215)) begin
          n_bad++;
          $display("FAIL extremes_val[%0d]: got %0d", n, q4_re);
        end
      end
    end
  endtask

  task automatic test_random_stall();
    int er, ei, ek;
    logic ed, ev;
    int cycles;
    logic st;
    rst4(1'b0);
    cycles = 0;
    while (xr.size() < 40 && cycles < 400) begin
      st = ($urandom_range(0, 9) < 3);
      cyc4(st, (xr.size() < 24) ? rnd24() : 0, (xr.size() < 24) ? rnd24() : 0);
      cycles++;
      model4(xr.size() - 1, er, ei, ed, ek, ev);
      n_cmp++;
      if (q4_re !== 25'(er) || q4_im !== 25'(ei) || q4_diff !== ed || q4_k !== 2'(ek) || q4_valid !== ev) begin
        n_bad++;
        $display("FAIL stall[%0d] st=%b: got re=%0d im=%0d diff=%b k=%0d valid=%b, want re=%0d im=%0d diff=%b k=%0d valid=%b",
                 cycles, st, q4_re, q4_im, q4_diff, q4_k, q4_valid, er, ei, ed, ek, ev);
      end
    end
  endtask

  task automatic test_reset_mid();
    int er, ei, ek;
    logic ed, ev;
    rst4(1'b0);
    for (int n = 0; n < 5; n++) cyc4(1'b0, rnd24(), rnd24());
    rst4(1'b1);
    for (int n = 0; n < 16; n++) begin
      if (n > 0) cyc4(1'b0, (n <= 8) ? n : 0, 0);
      model4(xr.size() - 1, er, ei, ed, ek, ev);
      n_cmp++;
      if (q4_re !== 25'(er) || q4_im !== 25'(ei) || q4_diff !== ed || q4_k !== 2'(ek) || q4_valid !== ev) begin
        n_bad++;
        $display("FAIL reset_mid[%0d]: got re=%0d im=%0d diff=%b k=%0d valid=%b, want re=%0d im=%0d diff=%b k=%0d valid=%b",
                 n, q4_re, q4_im, q4_diff, q4_k, q4_valid, er, ei, ed, ek, ev);
      end
    end
  endtask

  task automatic test_delay1();
    int din[6];
    int wre[6];
    logic wdiff[6];
    logic wval[6];
    din   = '{10, 4, 7, 1, 0, 0};
    wre   = '{0, 14, 6, 8, 6, 0};
    wdiff = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    wval  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    n_rst1 = 1'b0;
    stall1 = 1'b0;
    @(posedge clk);
    #1;
    n_rst1 = 1'b1;
    for (int n = 0; n < 6; n++) begin
      d1_re = DW'(din[n]);
      d1_im = '0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (q1_re !== 25'(wre[n]) || q1_im !== 25'sd0 || q1_diff !== wdiff[n] || q1_k !== 1'b0 || q1_valid !== wval[n]) begin
        n_bad++;
        $display("FAIL delay1[%0d]: got re=%0d im=%0d diff=%b k=%0d valid=%b, want re=%0d im=0 diff=%b k=0 valid=%b",
                 n, q1_re, q1_im, q1_diff, q1_k, q1_valid, wre[n], wdiff[n], wval[n]);
      end
    end
  endtask

  initial begin
    n_rst4 = 1'b0; stall4 = 1'b0; d4_re = '0; d4_im = '0;
    n_rst1 = 1'b0; stall1 = 1'b0; d1_re = '0; d1_im = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_complex();
    test_extremes();
    test_random_stall();
    test_reset_mid();
    test_delay1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
